// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, rx FSM state encoding and the
// majority-vote helper used by the receive sampler.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for rx_line plus a 3-sample mid-bit majority voter.
// vote is valid on the os_tick where os_cnt = OS_RATE/2+1.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OS_RATE = 16,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          os_tick,
    input  logic          rx_line,
    input  logic [CW-1:0] os_cnt,
    output logic          line_sync,
    output logic          vote
);

    localparam logic [CW-1:0] CNT_EARLY = CW'(OS_RATE / 2 - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(OS_RATE / 2);

    logic       sync_meta;
    logic [1:0] early;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            line_sync <= 1'b1;
            early     <= 2'b11;
        end else begin
            sync_meta <= rx_line;
            line_sync <= sync_meta;
            if (os_tick && os_cnt == CNT_EARLY) early[0] <= line_sync;
            if (os_tick && os_cnt == CNT_MID)   early[1] <= line_sync;
        end
    end

    // Third sample is the live synchronised value at the vote tick.
    assign vote = maj3(early[0], early[1], line_sync);

endmodule

// File: rtl/uart_rx_gen2.sv
// Oversampling UART receiver with parity/frame checks, break detection and a
// single-word holding register with overrun reporting.
module uart_rx_gen2
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OS_RATE     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun_error,
    output logic                 break_detect,
    output logic [2:0]           dbg_state
);

    localparam int CW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(OS_RATE - 1);
    localparam logic [CW-1:0] CNT_VOTE  = CW'(OS_RATE / 2 + 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic [2:0]           state;
    logic [CW-1:0]        os_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_err;
    logic                 stop_hi;
    logic                 brk_wait;
    logic                 line_sync;
    logic                 vote;
    logic                 par_err;
    logic                 is_break;

    uart_rx_sampler #(.OS_RATE(OS_RATE), .CW(CW)) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .os_tick  (os_tick),
        .rx_line  (rx_line),
        .os_cnt   (os_cnt),
        .line_sync(line_sync),
        .vote     (vote)
    );

    always_comb begin
        par_err = 1'b0;
        if (PARITY_MODE == PARITY_EVEN)     par_err = (^shreg) ^ par_bit;
        else if (PARITY_MODE == PARITY_ODD) par_err = ~((^shreg) ^ par_bit);
    end

    // Break: every data, parity and stop vote of the frame was 0.
    assign is_break = (shreg == '0) && (PARITY_MODE == PARITY_NONE || !par_bit) &&
                      !stop_hi && !vote;

    assign dbg_state = state;

    // Handshake: a word is transferred on any clk edge where rx_valid and
    // rx_ready are both high; rx_data and the status flags are held stable
    // from the edge that raises rx_valid until that transfer edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RX_IDLE;
            os_cnt        <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            stop_err      <= 1'b0;
            stop_hi       <= 1'b0;
            brk_wait      <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
            break_detect  <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            break_detect  <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            if (os_tick) begin
                os_cnt <= (os_cnt == CNT_LAST) ? '0 : os_cnt + 1'b1;
                case (state)
                    RX_IDLE: begin
                        os_cnt   <= '0;
                        bit_cnt  <= '0;
                        stop_err <= 1'b0;
                        stop_hi  <= 1'b0;
                        if (brk_wait) begin
                            if (line_sync) brk_wait <= 1'b0;
                        end else if (!line_sync) begin
                            state <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (os_cnt == CNT_VOTE && vote) begin
                            state  <= RX_IDLE;
                            os_cnt <= '0;
                        end else if (os_cnt == CNT_LAST) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        if (os_cnt == CNT_VOTE) shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (os_cnt == CNT_LAST) begin
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                state   <= (PARITY_MODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (os_cnt == CNT_VOTE) par_bit <= vote;
                        if (os_cnt == CNT_LAST) state <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (os_cnt == CNT_VOTE) begin
                            if (bit_cnt == STOP_LAST) begin
                                // Leave at mid-bit so an immediate next start edge is seen.
                                state   <= RX_IDLE;
                                os_cnt  <= '0;
                                bit_cnt <= '0;
                                if (is_break) begin
                                    break_detect <= 1'b1;
                                    brk_wait     <= 1'b1;
                                end else if (!rx_valid || rx_ready) begin
                                    rx_data      <= shreg;
                                    parity_error <= par_err;
                                    frame_error  <= stop_err | ~vote;
                                    rx_valid     <= 1'b1;
                                end else begin
                                    overrun_error <= 1'b1;
                                end
                            end else begin
                                stop_err <= stop_err | ~vote;
                                stop_hi  <= stop_hi | vote;
                            end
                        end else if (os_cnt == CNT_LAST) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= RX_IDLE;
                        os_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Directed bench for uart_rx_gen2: three configurations (8N1, 8E1, 7O2) driven
// bit-serially, checked by a frame-level model and a per-cycle compare process.
module tb_uart_rx_gen2;
    import uart_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os_tick = 1'b0;
    logic [1:0] tick_div = 2'd0;
    logic [2:0] lines = 3'b111;
    logic [2:0] rdy = 3'b000;
    logic [2:0] val, pe, fe, ov, bk;
    logic [7:0] rx_data_a, rx_data_e;
    logic [6:0] rx_data_o;
    logic [2:0] st_a, st_e, st_o;

    int checks = 0;
    int errors = 0;

    // Model state: expected words {idx[1:0], parity_err, frame_err, data[8:0]}
    logic [12:0] exp_q[$];
    bit          held[3];
    int          ovr_exp[3], brk_exp[3], ovr_obs[3], brk_obs[3];
    logic        p_v[3], p_acc[3], p_pe[3], p_fe[3];
    logic [8:0]  p_d[3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_div <= tick_div + 2'd1;
        os_tick  <= (tick_div == 2'd3);
    end

    uart_rx_gen2 #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OS_RATE(16)) dut_a (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx_line(lines[0]),
        .rx_data(rx_data_a), .rx_valid(val[0]), .rx_ready(rdy[0]),
        .parity_error(pe[0]), .frame_error(fe[0]), .overrun_error(ov[0]),
        .break_detect(bk[0]), .dbg_state(st_a)
    );

    uart_rx_gen2 #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OS_RATE(16)) dut_e (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx_line(lines[1]),
        .rx_data(rx_data_e), .rx_valid(val[1]), .rx_ready(rdy[1]),
        .parity_error(pe[1]), .frame_error(fe[1]), .overrun_error(ov[1]),
        .break_detect(bk[1]), .dbg_state(st_e)
    );

    uart_rx_gen2 #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .OS_RATE(16)) dut_o (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx_line(lines[2]),
        .rx_data(rx_data_o), .rx_valid(val[2]), .rx_ready(rdy[2]),
        .parity_error(pe[2]), .frame_error(fe[2]), .overrun_error(ov[2]),
        .break_detect(bk[2]), .dbg_state(st_o)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int idx, input logic v);
        lines[idx] = v;
        step(BIT_CLKS);
    endtask

    task automatic send_frame(input int idx, input logic [8:0] data, input int nbits,
                              input int pmode, input logic pbit, input int nstop,
                              input logic [1:0] stops);
        drive_bit(idx, 1'b0);
        for (int b = 0; b < nbits; b++) drive_bit(idx, data[b]);
        if (pmode != 0) drive_bit(idx, pbit);
        for (int s = 0; s < nstop; s++) drive_bit(idx, stops[s]);
        lines[idx] = 1'b1;
    endtask

    // Frame-level prediction: what the receiver must report for this frame.
    task automatic expect_frame(input int idx, input logic [8:0] data, input int pmode,
                                input logic pbit, input int nstop, input logic [1:0] stops);
        int   ones;
        logic perr, ferr, brk;
        ones = $countones(data) + int'(pbit);
        perr = (pmode == 1) ? (ones % 2 == 1) : (pmode == 2) ? (ones % 2 == 0) : 1'b0;
        ferr = !stops[0] || (nstop == 2 && !stops[1]);
        brk  = (data == 9'd0) && (pmode == 0 || !pbit) && !stops[0] && (nstop == 1 || !stops[1]);
        if (brk) brk_exp[idx]++;
        else if (held[idx]) ovr_exp[idx]++;
        else begin
            exp_q.push_back({2'(idx), perr, ferr, data});
            held[idx] = 1'b1;
        end
    endtask

    task automatic accept(input int idx);
        rdy[idx] = 1'b1;
        step(1);
        rdy[idx] = 1'b0;
        held[idx] = 1'b0;
    endtask

    task automatic mon(input int i, input logic v, input logic [8:0] d, input logic pe_i,
                       input logic fe_i, input logic ov_i, input logic bk_i, input logic rd);
        logic [12:0] e;
        if (ov_i) ovr_obs[i]++;
        if (bk_i) brk_obs[i]++;
        if (v && (!p_v[i] || p_acc[i])) begin
            checks++;
            if (exp_q.size() == 0 || int'(exp_q[0][12:11]) != i) begin
                errors++;
                $display("FAIL unexpected_word[%0d] got d=%h pe=%b fe=%b, none expected", i, d, pe_i, fe_i);
            end else begin
                e = exp_q.pop_front();
                if ({pe_i, fe_i, d} !== e[10:0]) begin
                    errors++;
                    $display("FAIL load_word[%0d] got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b",
                             i, d, pe_i, fe_i, e[8:0], e[10], e[9]);
                end
            end
        end else if (v) begin
            checks++;
            if ({pe_i, fe_i, d} !== {p_pe[i], p_fe[i], p_d[i]}) begin
                errors++;
                $display("FAIL held_stable[%0d] got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b",
                         i, d, pe_i, fe_i, p_d[i], p_pe[i], p_fe[i]);
            end
        end else if (p_v[i] && !p_acc[i]) begin
            checks++;
            errors++;
            $display("FAIL valid_dropped[%0d] got rx_valid=0 expected 1", i);
        end
        p_v[i]  = v;
        p_acc[i] = v && rd;
        p_d[i]  = d;
        p_pe[i] = pe_i;
        p_fe[i] = fe_i;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                p_v[i]   = 1'b0;
                p_acc[i] = 1'b0;
            end
        end else begin
            mon(0, val[0], {1'b0, rx_data_a}, pe[0], fe[0], ov[0], bk[0], rdy[0]);
            mon(1, val[1], {1'b0, rx_data_e}, pe[1], fe[1], ov[1], bk[1], rdy[1]);
            mon(2, val[2], {2'b0, rx_data_o}, pe[2], fe[2], ov[2], bk[2], rdy[2]);
        end
    end

    initial begin
        // Reset state
        step(3);
        chk("rst_valid", 16'(val), 16'h0);
        chk("rst_data_a", 16'(rx_data_a), 16'h0);
        chk("rst_flags", 16'({pe, fe, ov, bk}), 16'h0);
        rst = 1'b0;
        step(4);

        // 8N1 0xA5, held until rx_ready
        expect_frame(0, 9'h0A5, 0, 1'b0, 1, 2'b11);
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
        step(2);
        chk("a5_valid", 16'(val[0]), 16'h1);
        chk("a5_data", 16'(rx_data_a), 16'h00A5);
        chk("a5_err", 16'({pe[0], fe[0]}), 16'h0);
        step(3 * BIT_CLKS);
        chk("a5_hold_valid", 16'(val[0]), 16'h1);
        chk("a5_hold_data", 16'(rx_data_a), 16'h00A5);
        accept(0);
        chk("a5_accept_clear", 16'(val[0]), 16'h0);

        // 8E1 0x3C: parity bit 1 is wrong, parity bit 0 is right
        expect_frame(1, 9'h03C, 1, 1'b1, 1, 2'b11);
        send_frame(1, 9'h03C, 8, 1, 1'b1, 1, 2'b11);
        step(2);
        chk("e_bad_data", 16'(rx_data_e), 16'h003C);
        chk("e_bad_perr", 16'(pe[1]), 16'h1);
        accept(1);
        expect_frame(1, 9'h03C, 1, 1'b0, 1, 2'b11);
        send_frame(1, 9'h03C, 8, 1, 1'b0, 1, 2'b11);
        step(2);
        chk("e_good_valid", 16'(val[1]), 16'h1);
        chk("e_good_perr", 16'(pe[1]), 16'h0);
        accept(1);

        // 7O2 0x2B with correct odd parity, second stop bit low
        expect_frame(2, 9'h02B, 2, 1'b1, 2, 2'b01);
        send_frame(2, 9'h02B, 7, 2, 1'b1, 2, 2'b01);
        step(2);
        chk("o_data", 16'(rx_data_o), 16'h002B);
        chk("o_ferr", 16'(fe[2]), 16'h1);
        chk("o_perr", 16'(pe[2]), 16'h0);
        accept(2);

        // Back-to-back 0x11, 0x22 with rx_ready low: overrun, 0x11 kept
        expect_frame(0, 9'h011, 0, 1'b0, 1, 2'b11);
        send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11);
        expect_frame(0, 9'h022, 0, 1'b0, 1, 2'b11);
        send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11);
        step(2);
        chk("ovr_data", 16'(rx_data_a), 16'h0011);
        chk("ovr_pulses", 16'(ovr_obs[0]), 16'h1);

        // 4-tick glitch, then a 12-bit-time break
        lines[0] = 1'b0;
        step(4 * TICK_DIV);
        lines[0] = 1'b1;
        step(2 * BIT_CLKS);
        chk("glitch_data", 16'(rx_data_a), 16'h0011);
        expect_frame(0, 9'h000, 0, 1'b0, 1, 2'b00);
        lines[0] = 1'b0;
        step(12 * BIT_CLKS);
        lines[0] = 1'b1;
        step(2 * BIT_CLKS);
        chk("brk_pulses", 16'(brk_obs[0]), 16'h1);
        chk("brk_data", 16'(rx_data_a), 16'h0011);

        // Reset in the middle of 0x55 data bits, then 0x0F
        fork
            send_frame(0, 9'h055, 8, 0, 1'b0, 1, 2'b11);
            begin
                step(3 * BIT_CLKS + 20);
                #2 rst = 1'b1;
                for (int i = 0; i < 3; i++) held[i] = 1'b0;
                #1;
                chk("mid_rst_valid", 16'(val), 16'h0);
                chk("mid_rst_data", 16'(rx_data_a), 16'h0);
                chk("mid_rst_flags", 16'({pe, fe, ov, bk}), 16'h0);
                chk("mid_rst_state", 16'({st_a, st_e, st_o}), 16'({RX_IDLE, RX_IDLE, RX_IDLE}));
            end
        join
        step(5);
        rst = 1'b0;
        step(4);
        expect_frame(0, 9'h00F, 0, 1'b0, 1, 2'b11);
        send_frame(0, 9'h00F, 8, 0, 1'b0, 1, 2'b11);
        step(2);
        chk("post_rst_valid", 16'(val[0]), 16'h1);
        chk("post_rst_data", 16'(rx_data_a), 16'h000F);
        accept(0);
        step(BIT_CLKS);

        // Model bookkeeping against what was observed
        chk("exp_q_drained", 16'(exp_q.size()), 16'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("overrun_count[%0d]", i), 16'(ovr_obs[i]), 16'(ovr_exp[i]));
            chk($sformatf("break_count[%0d]", i), 16'(brk_obs[i]), 16'(brk_exp[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
